// File: rtl/traffic_display_driver_if.sv
// Purpose: generator-side inputs and lamp/display outputs of traffic_display_driver.
// Latency: none; this is wiring only.
// Backpressure: none; the inputs are level signals that the driver samples continuously.
// Ports: phase[1:0], count[31:0] from the generator.
//        lamp[3:0], seg[6:0], dig_en[1:0], disp_bcd[7:0], busy from the driver.
interface traffic_display_driver_if;
  logic [1:0]  phase;
  logic [31:0] count;
  logic [3:0]  lamp;
  logic [6:0]  seg;
  logic [1:0]  dig_en;
  logic [7:0]  disp_bcd;
  logic        busy;

  modport master (
    output phase, count,
    input  lamp, seg, dig_en, disp_bcd, busy
  );

  modport slave (
    input  phase, count,
    output lamp, seg, dig_en, disp_bcd, busy
  );
endinterface

// File: rtl/traffic_display_driver.sv
// Purpose: filter the generator's phase/countdown, drive the lamps, and show the count on a muxed two-digit 7-seg.
// Latency: held at edge 2, lamp at edge 3, BCD loaded at edge 3 and committed at edge 11 (edge 0 samples the input).
// Backpressure: none; a change that arrives mid-conversion waits in held and is converted once the engine is idle.
// Ports: clk, reset (async, active-high); bus (slave): phase, count in;
//        lamp {red,left,forward,right}, seg {g..a}, dig_en (01 units / 10 tens), disp_bcd, busy out.
module traffic_display_driver #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250000,
  parameter int BLINK_SECS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_display_driver_if.slave  bus
);

  typedef struct packed {
    logic [1:0]  phase;
    logic [31:0] count;
  } sample_t;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  // ---------------------------------------------------------------
  // Input capture: two-stage sampler, accept only a value seen on
  // two consecutive clk edges, so a one-cycle glitch never lands.
  // ---------------------------------------------------------------
  sample_t in_smp;
  sample_t s1, s2, held;
  logic    accept;
  logic    phase_chg;

  assign in_smp    = {bus.phase, bus.count};
  assign accept    = (s1 == s2) && (s2 != held);
  assign phase_chg = accept && (s2.phase != held.phase);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      held <= '0;
    end else begin
      s1 <= in_smp;
      s2 <= s1;
      if (accept) held <= s2;
    end
  end

  // The display only has two digits, so clamp the source before conversion.
  logic [6:0] conv_in;
  assign conv_in = (held.count > 32'd99) ? 7'd99 : held.count[6:0];

  // ---------------------------------------------------------------
  // Shift-add-3 BCD converter
  // ---------------------------------------------------------------
  conv_state_t state, n_state;
  logic [6:0]  sr, n_sr;
  logic [7:0]  scratch, n_scratch;
  logic [7:0]  adj;
  logic [2:0]  iter, n_iter;
  logic [6:0]  last_src, n_last_src;
  logic [7:0]  disp_q, n_disp;
  logic        busy_q, n_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      scratch  <= '0;
      iter     <= '0;
      last_src <= '0;
      disp_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= n_state;
      sr       <= n_sr;
      scratch  <= n_scratch;
      iter     <= n_iter;
      last_src <= n_last_src;
      disp_q   <= n_disp;
      busy_q   <= n_busy;
    end
  end

  always_comb begin
    n_state    = state;
    n_sr       = sr;
    n_scratch  = scratch;
    n_iter     = iter;
    n_last_src = last_src;
    n_disp     = disp_q;
    n_busy     = busy_q;
    adj        = scratch;
    case (state)
      IDLE: begin
        // last_src rather than held is compared, so a value that changed
        // during a conversion is picked up here on the next pass.
        if (conv_in != last_src) begin
          n_sr       = conv_in;
          n_scratch  = '0;
          n_iter     = '0;
          n_last_src = conv_in;
          n_busy     = 1'b1;
          n_state    = CONV;
        end
      end
      CONV: begin
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        {n_scratch, n_sr} = {adj[6:0], sr, 1'b0};
        n_iter = iter + 3'd1;
        if (iter == 3'd6) n_state = DONE;
      end
      DONE: begin
        n_disp  = scratch;
        n_busy  = 1'b0;
        n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Blink timer: restarted on a phase change so each phase opens lit;
  // the phase change takes priority over a coincident wrap.
  // ---------------------------------------------------------------
  logic [BW-1:0] bcnt;
  logic          blink_ph;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt     <= '0;
      blink_ph <= 1'b0;
    end else if (phase_chg) begin
      bcnt     <= '0;
      blink_ph <= 1'b0;
    end else if (bcnt == BLINK_MAX) begin
      bcnt     <= '0;
      blink_ph <= ~blink_ph;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Lamps
  // ---------------------------------------------------------------
  logic [3:0] lamp_q, n_lamp;
  logic       arrow_on;

  always_comb begin
    arrow_on = !((held.count <= 32'(BLINK_SECS)) && blink_ph);
    n_lamp   = 4'b1000;
    case (held.phase)
      2'b01:   n_lamp = {1'b0, arrow_on, 2'b00};
      2'b10:   n_lamp = {2'b00, arrow_on, 1'b0};
      2'b11:   n_lamp = {3'b000, arrow_on};
      default: n_lamp = 4'b1000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lamp_q <= 4'b1000;
    else       lamp_q <= n_lamp;
  end

  // ---------------------------------------------------------------
  // Digit scan: seg and dig_en move together at scan wrap only, so a
  // digit never shows a segment pattern meant for the other one.
  // ---------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [SW-1:0] scnt;
  logic [1:0]    dig_q, nxt_dig;
  logic [6:0]    seg_q, nxt_seg;

  always_comb begin
    nxt_dig = {dig_q[0], dig_q[1]};
    nxt_seg = seg7(disp_q[3:0]);
    if (nxt_dig == 2'b10) nxt_seg = (disp_q[7:4] == 4'd0) ? 7'h00 : seg7(disp_q[7:4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt  <= '0;
      dig_q <= 2'b01;
      seg_q <= '0;
    end else if (scnt == SCAN_MAX) begin
      scnt  <= '0;
      dig_q <= nxt_dig;
      seg_q <= nxt_seg;
    end else begin
      scnt <= scnt + SW'(1);
    end
  end

  assign bus.lamp     = lamp_q;
  assign bus.seg      = seg_q;
  assign bus.dig_en   = dig_q;
  assign bus.disp_bcd = disp_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Purpose: directed bench for traffic_display_driver with short scan/blink dividers.
// Latency: checks the edge-exact timing of held, lamp, busy and disp_bcd.
// Backpressure: none; inputs are driven one cycle-aligned step at a time.
module tb_traffic_display_driver;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   ed;

  traffic_display_driver_if bus ();

  traffic_display_driver #(
    .SCAN_DIV  (2),
    .BLINK_DIV (4),
    .BLINK_SECS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive new inputs just after a rising edge; the next edge is edge 0.
  task automatic apply(input logic [1:0] p, input logic [31:0] c);
    @(posedge clk);
    #1;
    bus.phase = p;
    bus.count = c;
    ed = -1;
  endtask

  // Advance to just after edge k of the current transaction.
  task automatic to_edge(input int k);
    while (ed < k) begin
      @(posedge clk);
      ed++;
    end
    #1;
  endtask

  // Watch four scan cycles once the committed value has reached the segments.
  task automatic scan_chk(input logic [6:0] t, input logic [6:0] u);
    int st;
    int su;
    st = 0;
    su = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.dig_en == 2'b10) begin
        st++;
        chk("seg_tens", 32'(bus.seg), 32'(t));
      end else begin
        su++;
        chk("dig_units", 32'(bus.dig_en), 32'h1);
        chk("seg_units", 32'(bus.seg), 32'(u));
      end
    end
    chk("scan_hold", 32'(st == 2 && su == 2), 32'h1);
  endtask

  initial begin
    int busy_seen;
    n_checks  = 0;
    n_errors  = 0;
    ed        = 0;
    reset     = 1'b1;
    bus.phase = 2'b00;
    bus.count = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lamp", 32'(bus.lamp), 32'h8);
    chk("rst_seg", 32'(bus.seg), 32'h0);
    chk("rst_dig", 32'(bus.dig_en), 32'h1);
    chk("rst_disp", 32'(bus.disp_bcd), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Latency: FORWARD, 15
    apply(2'b10, 32'd15);
    to_edge(2);
    chk("lat_busy_e2", 32'(bus.busy), 32'h0);
    chk("lat_lamp_e2", 32'(bus.lamp), 32'h8);
    for (int k = 3; k <= 10; k++) begin
      to_edge(k);
      chk("lat_busy_hi", 32'(bus.busy), 32'h1);
      if (k == 3) chk("lat_lamp_e3", 32'(bus.lamp), 32'h2);
      if (k == 10) chk("lat_disp_e10", 32'(bus.disp_bcd), 32'h0);
    end
    to_edge(11);
    chk("lat_busy_e11", 32'(bus.busy), 32'h0);
    chk("lat_disp_e11", 32'(bus.disp_bcd), 32'h15);
    scan_chk(7'h06, 7'h6D);

    // Saturation
    apply(2'b10, 32'd1000);
    to_edge(11);
    chk("sat_disp", 32'(bus.disp_bcd), 32'h99);
    scan_chk(7'h6F, 7'h6F);

    // Settle on 10, then a one-cycle glitch to 7
    apply(2'b10, 32'd10);
    to_edge(12);
    chk("ten_disp", 32'(bus.disp_bcd), 32'h10);
    scan_chk(7'h06, 7'h3F);
    apply(2'b10, 32'd7);
    @(posedge clk);
    #1;
    bus.count = 32'd10;
    busy_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_seen++;
    end
    chk("glitch_busy", 32'(busy_seen), 32'h0);
    chk("glitch_disp", 32'(bus.disp_bcd), 32'h10);

    // Back-to-back: 10 converting, 9 arrives at edge 5
    apply(2'b10, 32'd20);
    to_edge(12);
    chk("b2b_pre", 32'(bus.disp_bcd), 32'h20);
    apply(2'b10, 32'd10);
    to_edge(4);
    bus.count = 32'd9;
    to_edge(11);
    chk("b2b_first", 32'(bus.disp_bcd), 32'h10);
    chk("b2b_busy11", 32'(bus.busy), 32'h0);
    to_edge(12);
    chk("b2b_busy12", 32'(bus.busy), 32'h1);
    to_edge(19);
    chk("b2b_hold19", 32'(bus.disp_bcd), 32'h10);
    to_edge(20);
    chk("b2b_second", 32'(bus.disp_bcd), 32'h09);
    chk("b2b_busy20", 32'(bus.busy), 32'h0);
    scan_chk(7'h00, 7'h6F);

    // Blink: LEFT with count 3, lit 4 cycles then dark 4 cycles
    apply(2'b01, 32'd3);
    for (int k = 3; k <= 14; k++) begin
      to_edge(k);
      chk("blink_left", 32'(bus.lamp), (((k - 3) / 4) % 2 == 0) ? 32'h4 : 32'h0);
    end

    // OFF: steady red
    apply(2'b00, 32'd3);
    for (int k = 3; k <= 14; k++) begin
      to_edge(k);
      chk("off_red", 32'(bus.lamp), 32'h8);
    end

    // Count above the blink threshold: steady arrow
    apply(2'b01, 32'd4);
    for (int k = 3; k <= 14; k++) begin
      to_edge(k);
      chk("noblink", 32'(bus.lamp), 32'h4);
    end
    to_edge(15);
    chk("four_disp", 32'(bus.disp_bcd), 32'h04);

    // Reset in the middle of a conversion
    apply(2'b10, 32'd15);
    to_edge(5);
    reset = 1'b1;
    #1;
    chk("mid_rst_lamp", 32'(bus.lamp), 32'h8);
    chk("mid_rst_disp", 32'(bus.disp_bcd), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ed = -1;
    to_edge(10);
    chk("post_rst_busy", 32'(bus.busy), 32'h1);
    to_edge(11);
    chk("post_rst_disp", 32'(bus.disp_bcd), 32'h15);
    chk("post_rst_lamp", 32'(bus.lamp), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
